// File: rtl/id_ex_forward_reg.sv
// ID/EX pipeline register with next-cycle forwarding selects and load-use bubble insertion.
// Latency: one cycle ID -> EX; hazard_stall is combinational; stall_in freezes all state.
module id_ex_forward_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_dst,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_W-1:0]  exmem_dst,
  input  logic              exmem_regwrite,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_dst,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              regwrite;
    logic              memread;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  ex_t             ex_q, ex_d, id_pkt;
  logic [1:0]      fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            ex_writes, mem_writes, hazard;

  assign id_pkt = '{valid: id_valid, rs: id_rs, rt: id_rt, dst: id_dst,
                    rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm,
                    regwrite: id_regwrite, memread: id_memread, ctrl: id_ctrl};

  // Register $0 is hard-wired zero, so a write to it never produces a forwardable value.
  assign ex_writes  = ex_q.valid & ex_q.regwrite & (ex_q.dst != '0);
  assign mem_writes = exmem_regwrite & (exmem_dst != '0);

  assign hazard = ex_writes & ex_q.memread & id_valid &
                  ((id_uses_rs & (id_rs == ex_q.dst)) | (id_uses_rt & (id_rt == ex_q.dst)));

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src, input logic uses);
    if (!(id_valid && uses))                 return 2'b00;
    else if (ex_writes && ex_q.dst == src)   return 2'b10;
    else if (mem_writes && exmem_dst == src) return 2'b01;
    else                                     return 2'b00;
  endfunction

  always_comb begin
    ex_d    = ex_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    cnt_d   = cnt_q;
    if (stall_in) begin
      ex_d = ex_q;
    end else if (flush || hazard) begin
      ex_d    = '0;
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
      if (!flush && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else begin
      ex_d    = id_pkt;
      fwd_a_d = fwd_sel(id_rs, id_uses_rs);
      fwd_b_d = fwd_sel(id_rt, id_uses_rt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= '0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_dst       = ex_q.dst;
  assign ex_rs_data   = ex_q.rs_data;
  assign ex_rt_data   = ex_q.rt_data;
  assign ex_imm       = ex_q.imm;
  assign ex_regwrite  = ex_q.regwrite;
  assign ex_memread   = ex_q.memread;
  assign ex_ctrl      = ex_q.ctrl;
  assign fwd_a_sel    = fwd_a_q;
  assign fwd_b_sel    = fwd_b_q;
  assign hazard_stall = hazard;
  assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_forward_reg.sv
// Directed-vector bench for id_ex_forward_reg; a second instance with a 4-bit counter
// exercises counter saturation within a short run.
module tb_id_ex_forward_reg;

  typedef struct packed {
    logic        haz;
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic        rw;
    logic        mr;
    logic [7:0]  ctrl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } exp_t;

  typedef enum int {K_LOAD, K_BUB, K_HOLD, K_RST} kind_e;

  logic clk = 1'b0;
  logic reset = 1'b1, stall_in = 1'b0, flush = 1'b0;
  logic id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
  logic id_regwrite = 1'b0, id_memread = 1'b0, exmem_regwrite = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_dst = '0, exmem_dst = '0;
  logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [7:0]  id_ctrl = '0;

  logic        b_valid, b_rw, b_mr, b_haz, s_valid, s_rw, s_mr, s_haz;
  logic [4:0]  b_rs, b_rt, b_dst, s_rs, s_rt, s_dst;
  logic [31:0] b_rs_data, b_rt_data, b_imm, s_rs_data, s_rt_data, s_imm;
  logic [7:0]  b_ctrl, s_ctrl;
  logic [1:0]  b_fa, b_fb, s_fa, s_fb;
  logic [15:0] b_cnt;
  logic [3:0]  s_cnt;
  exp_t        obs_b, obs_s;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t last_e = '0;

  always #5 clk = ~clk;

  id_ex_forward_reg dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ctrl(id_ctrl),
    .exmem_dst(exmem_dst), .exmem_regwrite(exmem_regwrite),
    .ex_valid(b_valid), .ex_rs(b_rs), .ex_rt(b_rt), .ex_dst(b_dst),
    .ex_rs_data(b_rs_data), .ex_rt_data(b_rt_data), .ex_imm(b_imm),
    .ex_regwrite(b_rw), .ex_memread(b_mr), .ex_ctrl(b_ctrl),
    .fwd_a_sel(b_fa), .fwd_b_sel(b_fb), .hazard_stall(b_haz), .bubble_count(b_cnt)
  );

  id_ex_forward_reg #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ctrl(id_ctrl),
    .exmem_dst(exmem_dst), .exmem_regwrite(exmem_regwrite),
    .ex_valid(s_valid), .ex_rs(s_rs), .ex_rt(s_rt), .ex_dst(s_dst),
    .ex_rs_data(s_rs_data), .ex_rt_data(s_rt_data), .ex_imm(s_imm),
    .ex_regwrite(s_rw), .ex_memread(s_mr), .ex_ctrl(s_ctrl),
    .fwd_a_sel(s_fa), .fwd_b_sel(s_fb), .hazard_stall(s_haz), .bubble_count(s_cnt)
  );

  assign obs_b = {b_haz, b_valid, b_rs, b_rt, b_dst, b_rs_data, b_rt_data, b_imm,
                  b_rw, b_mr, b_ctrl, b_fa, b_fb, b_cnt};
  assign obs_s = {s_haz, s_valid, s_rs, s_rt, s_dst, s_rs_data, s_rt_data, s_imm,
                  s_rw, s_mr, s_ctrl, s_fa, s_fb, 12'd0, s_cnt};

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step%0d %s: got %0h expected %0h", idx, nm, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input int idx, input exp_t e, input logic haz, input exp_t o);
    chk({tag, ".hazard_stall"}, idx, 32'(haz), 32'(e.haz));
    chk({tag, ".ex_valid"},     idx, 32'(o.valid), 32'(e.valid));
    chk({tag, ".ex_rs"},        idx, 32'(o.rs), 32'(e.rs));
    chk({tag, ".ex_rt"},        idx, 32'(o.rt), 32'(e.rt));
    chk({tag, ".ex_dst"},       idx, 32'(o.dst), 32'(e.dst));
    chk({tag, ".ex_rs_data"},   idx, o.rs_data, e.rs_data);
    chk({tag, ".ex_rt_data"},   idx, o.rt_data, e.rt_data);
    chk({tag, ".ex_imm"},       idx, o.imm, e.imm);
    chk({tag, ".ex_regwrite"},  idx, 32'(o.rw), 32'(e.rw));
    chk({tag, ".ex_memread"},   idx, 32'(o.mr), 32'(e.mr));
    chk({tag, ".ex_ctrl"},      idx, 32'(o.ctrl), 32'(e.ctrl));
    chk({tag, ".fwd_a_sel"},    idx, 32'(o.fa), 32'(e.fa));
    chk({tag, ".fwd_b_sel"},    idx, 32'(o.fb), 32'(e.fb));
    chk({tag, ".bubble_count"}, idx, 32'(o.cnt), 32'(e.cnt));
  endtask

  // Monitor: hazard sampled mid-cycle before the edge, registers sampled just after it.
  initial begin : monitor
    exp_t e, es;
    logic hb, hs;
    int   idx = 0;
    forever begin
      @(negedge clk); #3;
      hb = b_haz;
      hs = s_haz;
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        es = e;
        es.cnt = (e.cnt > 16'd15) ? 16'd15 : e.cnt;
        cmp("big", idx, e, hb, obs_b);
        cmp("sat4", idx, es, hs, obs_s);
        idx++;
      end
    end
  end

  task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] dst,
                        input bit urs, input bit urt, input bit rw, input bit mr);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_dst      = dst;
    id_uses_rs  = urs;
    id_uses_rt  = urt;
    id_regwrite = rw;
    id_memread  = mr;
    id_rs_data  = 32'h1000_0000 + 32'(rs);
    id_rt_data  = 32'h2000_0000 + 32'(rt);
    id_imm      = 32'hFFFF_FF00 | 32'(dst);
    id_ctrl     = 8'hC0 | 8'(dst);
  endtask

  task automatic set_mem(input bit rw, input bit [4:0] dst);
    exmem_regwrite = rw;
    exmem_dst      = dst;
  endtask

  // Push the expected post-edge state for the inputs now driven, then advance one cycle.
  task automatic step(input kind_e k, input bit haz, input bit [1:0] fa, input bit [1:0] fb,
                      input int cnt);
    exp_t e;
    e = last_e;
    case (k)
      K_LOAD: e = {1'b0, id_valid, id_rs, id_rt, id_dst, id_rs_data, id_rt_data, id_imm,
                   id_regwrite, id_memread, id_ctrl, 2'b00, 2'b00, 16'd0};
      K_BUB, K_RST: e = '0;
      default: e = last_e;
    endcase
    e.haz = haz;
    e.fa  = fa;
    e.fb  = fb;
    e.cnt = 16'(cnt);
    sb.push_back(e);
    last_e = e;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    int cnt;
    @(negedge clk);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_mem(0, 0);
    step(K_RST, 0, 2'b00, 2'b00, 0);
    reset = 1'b0;

    // EX->EX forwarding: add $3 then sub reading $3
    set_id(1, 1, 2, 3, 1, 1, 1, 0);   step(K_LOAD, 0, 2'b00, 2'b00, 0);
    set_id(1, 3, 4, 6, 1, 1, 1, 0);   step(K_LOAD, 0, 2'b10, 2'b00, 0);
    // MEM/WB forwarding on rt, then $0 suppression, unused operands, invalid ID
    set_mem(1, 4);
    set_id(1, 8, 4, 9, 1, 1, 1, 0);   step(K_LOAD, 0, 2'b00, 2'b01, 0);
    set_mem(1, 0);
    set_id(1, 0, 0, 10, 1, 1, 1, 0);  step(K_LOAD, 0, 2'b00, 2'b00, 0);
    set_mem(1, 4);
    set_id(1, 4, 4, 11, 0, 0, 1, 0);  step(K_LOAD, 0, 2'b00, 2'b00, 0);
    set_id(0, 4, 4, 12, 1, 1, 1, 0);  step(K_LOAD, 0, 2'b00, 2'b00, 0);
    // Load-use: bubble, then dependent enters with MEM/WB select
    set_mem(0, 0);
    set_id(1, 1, 2, 5, 1, 0, 1, 1);   step(K_LOAD, 0, 2'b00, 2'b00, 0);
    set_id(1, 5, 6, 7, 1, 1, 1, 0);   step(K_BUB, 1, 2'b00, 2'b00, 1);
    set_mem(1, 5);                    step(K_LOAD, 0, 2'b01, 2'b00, 1);
    // Hazard with flush: bubble, no count
    set_mem(0, 0);
    set_id(1, 1, 2, 5, 1, 0, 1, 1);   step(K_LOAD, 0, 2'b00, 2'b00, 1);
    set_id(1, 5, 6, 7, 1, 1, 1, 0);
    flush = 1'b1;                     step(K_BUB, 1, 2'b00, 2'b00, 1);
    flush = 1'b0;
    // Hazard with stall_in: everything holds, then hazard resolves
    set_id(1, 1, 2, 5, 1, 0, 1, 1);   step(K_LOAD, 0, 2'b00, 2'b00, 1);
    set_id(1, 5, 6, 7, 1, 1, 1, 0);
    stall_in = 1'b1;                  step(K_HOLD, 1, 2'b00, 2'b00, 1);
    stall_in = 1'b0;                  step(K_BUB, 1, 2'b00, 2'b00, 2);
    // EX and EX/MEM both write $7: newest wins on both operands
    set_id(1, 1, 2, 7, 1, 0, 1, 0);   step(K_LOAD, 0, 2'b00, 2'b00, 2);
    set_mem(1, 7);
    set_id(1, 7, 7, 8, 1, 1, 1, 0);   step(K_LOAD, 0, 2'b10, 2'b10, 2);
    // A write to $0 in EX is never forwarded
    set_mem(0, 0);
    set_id(1, 1, 2, 0, 1, 1, 1, 0);   step(K_LOAD, 0, 2'b00, 2'b00, 2);
    set_id(1, 0, 0, 9, 1, 1, 1, 0);   step(K_LOAD, 0, 2'b00, 2'b00, 2);
    // Repeated load-use bubbles drive the 4-bit counter into saturation
    cnt = 2;
    for (int i = 0; i < 16; i++) begin
      set_id(1, 1, 2, 5, 1, 0, 1, 1); step(K_LOAD, 0, 2'b00, 2'b00, cnt);
      cnt++;
      set_id(1, 5, 6, 7, 1, 1, 1, 0); step(K_BUB, 1, 2'b00, 2'b00, cnt);
    end
    // Reset while a hazard is pending
    set_id(1, 1, 2, 5, 1, 0, 1, 1);   step(K_LOAD, 0, 2'b00, 2'b00, cnt);
    set_id(1, 5, 6, 7, 1, 1, 1, 0);
    reset = 1'b1;                     step(K_RST, 1, 2'b00, 2'b00, 0);
    reset = 1'b0;                     step(K_LOAD, 0, 2'b00, 2'b00, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);   step(K_LOAD, 0, 2'b00, 2'b00, 0);

    @(posedge clk); #2;
    chk("scoreboard_drained", -1, 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
